fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage of the 5-stage ARM pipeline. It owns the PC and the PC+4 adder, and drives the address/request to instruction memory. It captures the returned word and its PC+4 into the IF/ID pipeline register, and feeds the decode/control unit directly downstream. It honours hazard-unit stalls and branch redirects, and tolerates a variable-latency instruction memory through a req/ready handshake.

Parameters:
ADDR_W, 32, PC / memory address width
RESET_PC, 0, PC value loaded on reset
NOP_INSTR, 32'h0000_0000, word placed in IF/ID when empty or flushed

Ports:
CLK  in  1  rising-edge clock
CLR  in  1  reset; asynchronous, active-low
imem_addr  out  ADDR_W  fetch address (equals current PC)
imem_req  out  1  fetch request
imem_rdata  in  32  instruction word from memory
imem_ready  in  1  imem_rdata valid for imem_addr this cycle
stall  in  1  hazard unit: hold PC and IF/ID
br_taken  in  1  branch resolved taken this cycle
br_target  in  ADDR_W  branch destination
ifid_instr  out  32  IF/ID instruction to control unit
ifid_pc4  out  ADDR_W  IF/ID PC+4 of that instruction
ifid_valid  out  1  IF/ID holds a real instruction

Behaviour:
- Reset (CLR=0, async): PC=RESET_PC, state=BOOT, ifid_instr=NOP_INSTR, ifid_pc4=0, ifid_valid=0, hold buffer cleared, imem_req=0.
- FSM states: BOOT, FETCH, HELD.
- BOOT:
  - imem_req=0.
  - Next edge goes to FETCH, giving one idle cycle after reset release.
- FETCH:
  - imem_req=1; imem_addr=PC.
  - imem_ready=1 and stall=0: at the edge, IF/ID <= {imem_rdata, PC+4, valid=1}; PC <= PC+4. Stay in FETCH.
  - imem_ready=1 and stall=1: at the edge, store the word and its PC+4 in the hold buffer; PC <= PC+4; go to HELD. IF/ID is unchanged.
  - imem_ready=0 and stall=0: IF/ID <= bubble (NOP_INSTR, valid=0); PC is unchanged.
  - imem_ready=0 and stall=1: IF/ID and PC are unchanged.
- HELD:
  - imem_req=0.
  - stall=1: everything holds.
  - stall=0: at the edge, IF/ID <= hold buffer with valid=1; go to FETCH.
- Branch handling: br_taken has highest priority, in any state other than BOOT, and regardless of stall.
  - At the edge, PC <= br_target.
  - The hold buffer is discarded.
  - Any imem_rdata returned in the same cycle is discarded.
  - IF/ID is flushed to NOP_INSTR with valid=0.
  - State goes to FETCH.
- br_taken during BOOT: PC <= br_target; state still goes to FETCH.
- Memory contract: imem_addr may change while imem_req=1. Memory must answer for the current address; this matches the combinational instruction RAM.
- Arithmetic: PC+4 is an ADDR_W-bit modulo add. PC=2^ADDR_W−4 wraps to 0 with no flag.
- Throughput: with imem_ready tied to 1 and no stalls or branches, one instruction per cycle. Latency is one edge from address to IF/ID output.
- Invariant: imem_addr always equals PC.

Optional Feature:
IF_DELAY_SLOT_EN
- Defined: on br_taken, the IF/ID contents are kept, giving one architectural delay slot. Only the hold buffer and same-cycle imem_rdata are discarded. If IF/ID is not held by stall, IF/ID is loaded with a bubble (valid=0).
- Undefined: IF/ID is flushed as described in Behaviour.

Decomposition:
- Shared package holds:
  - fetch_state_t enum {BOOT, FETCH, HELD}
  - NOP_INSTR constant
  - RESET_PC default
  - IF/ID field struct {instr, pc4, valid}
- One natural sub-module: fetch_ifid_reg.
  - Contents: the IF/ID register with load, hold and flush controls, plus async active-low clear.
  - Role: reused by the top-level pipeline integration.

Test Plan:
- Reset: CLR low mid-cycle -> all outputs reach reset values immediately. After release: one BOOT cycle with imem_req=0, then imem_addr=0.
- Streaming: imem_ready=1, words A,B,C at addresses 0,4,8 -> ifid_instr=A/B/C on successive edges; ifid_pc4=4/8/12; ifid_valid=1.
- Wait states: imem_ready low 2 cycles at PC=8 -> imem_addr stays 8; IF/ID shows 2 bubbles (valid=0); then word loads with ifid_pc4=12.
- Stall with capture: stall=1 while imem_ready=1 at PC=4 -> IF/ID holds the previous word; imem_addr=8 with req=0. On stall release, IF/ID gets the word from address 4 with pc4=8.
- Branch over stall: stall=1, br_taken=1, br_target=0x40 -> next imem_addr=0x40; IF/ID=NOP with valid=0; held word dropped. With IF_DELAY_SLOT_EN, IF/ID is unchanged instead.
- Wrap: RESET_PC=32'hFFFF_FFFC with streaming -> ifid_pc4=0; next imem_addr=0.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared types and defaults for the instruction-fetch stage and its IF/ID register.
package fetch_stage_pkg;

    localparam int          ADDR_W_DEF    = 32;
    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HELD  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0]           instr;
        logic [ADDR_W_DEF-1:0] pc4;
        logic                  valid;
    } ifid_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction-memory handshake, hazard/branch controls and IF/ID outputs.
interface fetch_stage_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_req;
    logic [31:0]       imem_rdata;
    logic              imem_ready;
    logic              stall;
    logic              br_taken;
    logic [ADDR_W-1:0] br_target;
    logic [31:0]       ifid_instr;
    logic [ADDR_W-1:0] ifid_pc4;
    logic              ifid_valid;

    modport master (
        output imem_addr, imem_req, ifid_instr, ifid_pc4, ifid_valid,
        input  imem_rdata, imem_ready, stall, br_taken, br_target
    );

    modport slave (
        input  imem_addr, imem_req, ifid_instr, ifid_pc4, ifid_valid,
        output imem_rdata, imem_ready, stall, br_taken, br_target
    );
endinterface

// File: rtl/fetch_ifid_reg.sv
// IF/ID pipeline register: flush beats load, otherwise holds; async active-low clear.
module fetch_ifid_reg
    import fetch_stage_pkg::*;
#(
    parameter int          ADDR_W    = ADDR_W_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              flush,
    input  logic [31:0]       d_instr,
    input  logic [ADDR_W-1:0] d_pc4,
    output logic [31:0]       q_instr,
    output logic [ADDR_W-1:0] q_pc4,
    output logic              q_valid
);
    logic [31:0]       instr_r;
    logic [ADDR_W-1:0] pc4_r;
    logic              valid_r;

    // IF/ID storage with flush-over-load priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_r <= NOP_INSTR;
            pc4_r   <= '0;
            valid_r <= 1'b0;
        end else if (flush) begin
            instr_r <= NOP_INSTR;
            pc4_r   <= '0;
            valid_r <= 1'b0;
        end else if (load) begin
            instr_r <= d_instr;
            pc4_r   <= d_pc4;
            valid_r <= 1'b1;
        end else begin
            instr_r <= instr_r;
            pc4_r   <= pc4_r;
            valid_r <= valid_r;
        end
    end

    assign q_instr = instr_r;
    assign q_pc4   = pc4_r;
    assign q_valid = valid_r;
endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, PC+4, imem handshake, stall hold buffer, branch redirect.
// Optional macro IF_DELAY_SLOT_EN keeps IF/ID on a taken branch while stalled (delay slot).
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int                ADDR_W    = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(RESET_PC_DEF),
    parameter logic [31:0]       NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic          CLK,
    input  logic          CLR,
    fetch_stage_if.master bus
);
    fetch_state_t      state_r, state_nx_s;
    logic [ADDR_W-1:0] pc_r, pc_nx_s, pc4_s;
    logic              req_r;
    logic [31:0]       hold_instr_r;
    logic [ADDR_W-1:0] hold_pc4_r;
    logic              hold_load_s, hold_clr_s;
    logic              ifid_load_s, ifid_flush_s, br_flush_s;
    logic [31:0]       load_instr_s;
    logic [ADDR_W-1:0] load_pc4_s;

    assign pc4_s = pc_r + ADDR_W'(32'd4);

`ifdef IF_DELAY_SLOT_EN
    assign br_flush_s = ~bus.stall;
`else
    assign br_flush_s = 1'b1;
`endif

    // Next-state, next-PC and IF/ID / hold-buffer control decode
    always_comb begin
        state_nx_s   = state_r;
        pc_nx_s      = pc_r;
        load_instr_s = bus.imem_rdata;
        load_pc4_s   = pc4_s;
        ifid_load_s  = 1'b0;
        ifid_flush_s = 1'b0;
        hold_load_s  = 1'b0;
        hold_clr_s   = 1'b0;
        case (state_r)
            BOOT: begin
                state_nx_s = FETCH;
                if (bus.br_taken) begin
                    pc_nx_s = bus.br_target;
                end else begin
                    pc_nx_s = pc_r;
                end
            end
            FETCH: begin
                if (bus.br_taken) begin
                    pc_nx_s      = bus.br_target;
                    hold_clr_s   = 1'b1;
                    ifid_flush_s = br_flush_s;
                    state_nx_s   = FETCH;
                end else if (bus.imem_ready) begin
                    pc_nx_s = pc4_s;
                    if (bus.stall) begin
                        hold_load_s = 1'b1;
                        state_nx_s  = HELD;
                    end else begin
                        ifid_load_s = 1'b1;
                        state_nx_s  = FETCH;
                    end
                end else begin
                    ifid_flush_s = ~bus.stall;
                    state_nx_s   = FETCH;
                end
            end
            HELD: begin
                if (bus.br_taken) begin
                    pc_nx_s      = bus.br_target;
                    hold_clr_s   = 1'b1;
                    ifid_flush_s = br_flush_s;
                    state_nx_s   = FETCH;
                end else if (!bus.stall) begin
                    load_instr_s = hold_instr_r;
                    load_pc4_s   = hold_pc4_r;
                    ifid_load_s  = 1'b1;
                    state_nx_s   = FETCH;
                end else begin
                    state_nx_s = HELD;
                end
            end
            default: begin
                state_nx_s = BOOT;
            end
        endcase
    end

    // State, PC and registered request; req follows the state being entered
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_r <= BOOT;
            pc_r    <= RESET_PC;
            req_r   <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            pc_r    <= pc_nx_s;
            req_r   <= (state_nx_s == FETCH);
        end
    end

    // Hold buffer: word captured while IF/ID is stalled
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            hold_instr_r <= 32'h0000_0000;
            hold_pc4_r   <= '0;
        end else if (hold_clr_s) begin
            hold_instr_r <= 32'h0000_0000;
            hold_pc4_r   <= '0;
        end else if (hold_load_s) begin
            hold_instr_r <= bus.imem_rdata;
            hold_pc4_r   <= pc4_s;
        end else begin
            hold_instr_r <= hold_instr_r;
            hold_pc4_r   <= hold_pc4_r;
        end
    end

    fetch_ifid_reg #(
        .ADDR_W    (ADDR_W),
        .NOP_INSTR (NOP_INSTR)
    ) u_ifid (
        .clk     (CLK),
        .rst_n   (CLR),
        .load    (ifid_load_s),
        .flush   (ifid_flush_s),
        .d_instr (load_instr_s),
        .d_pc4   (load_pc4_s),
        .q_instr (bus.ifid_instr),
        .q_pc4   (bus.ifid_pc4),
        .q_valid (bus.ifid_valid)
    );

    assign bus.imem_addr = pc_r;
    assign bus.imem_req  = req_r;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with an IF/ID scoreboard and a second instance for PC wrap.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic clk;
    logic clr_n;
    int   total;
    int   bad;
    ifid_t exp_q[$];

    fetch_stage_if #(.ADDR_W(32)) bus  ();
    fetch_stage_if #(.ADDR_W(32)) bus2 ();

    fetch_stage #(.ADDR_W(32), .RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0000)) dut (
        .CLK (clk),
        .CLR (clr_n),
        .bus (bus.master)
    );

    fetch_stage #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(32'h0000_0000)) dut_wrap (
        .CLK (clk),
        .CLR (clr_n),
        .bus (bus2.master)
    );

    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[15:0] ^ 16'hA5C3, ~a[15:0]};
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational instruction memory for both instances
    always_comb bus.imem_rdata  = word(bus.imem_addr);
    always_comb bus2.imem_rdata = word(bus2.imem_addr);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [31:0] instr, input logic [31:0] pc4, input logic valid);
        ifid_t e;
        e.instr = instr;
        e.pc4   = pc4;
        e.valid = valid;
        exp_q.push_back(e);
    endtask

    task automatic sb_check(input string tag);
        ifid_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s_sb_empty observed=0 expected=1", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_instr"}, 64'(bus.ifid_instr), 64'(e.instr));
            chk({tag, "_valid"}, 64'(bus.ifid_valid), 64'(e.valid));
            if (e.valid) chk({tag, "_pc4"}, 64'(bus.ifid_pc4), 64'(e.pc4));
        end
    endtask

    task automatic cyc(input logic ready, input logic stl, input logic br, input logic [31:0] tgt);
        bus.imem_ready = ready;
        bus.stall      = stl;
        bus.br_taken   = br;
        bus.br_target  = tgt;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        clr_n = 1'b0;
        bus.imem_ready  = 1'b0;
        bus.stall       = 1'b0;
        bus.br_taken    = 1'b0;
        bus.br_target   = 32'h0000_0000;
        bus2.imem_ready = 1'b1;
        bus2.stall      = 1'b0;
        bus2.br_taken   = 1'b0;
        bus2.br_target  = 32'h0000_0000;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_req",   64'(bus.imem_req),   64'd0);
        chk("rst_addr",  64'(bus.imem_addr),  64'd0);
        chk("rst_instr", 64'(bus.ifid_instr), 64'd0);
        chk("rst_pc4",   64'(bus.ifid_pc4),   64'd0);
        chk("rst_valid", 64'(bus.ifid_valid), 64'd0);

        @(negedge clk);
        clr_n = 1'b1;
        #1;
        chk("boot_req",  64'(bus.imem_req),  64'd0);
        chk("boot_addr", 64'(bus.imem_addr), 64'd0);

        push(32'h0000_0000, 32'h0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        sb_check("boot_edge");
        chk("fetch_req",  64'(bus.imem_req),   64'd1);
        chk("fetch_addr", 64'(bus.imem_addr),  64'd0);
        chk("wrap_addr0", 64'(bus2.imem_addr), 64'hFFFF_FFFC);

        // Streaming at 0, 4, 8
        for (int i = 0; i < 3; i++) begin
            push(word(32'(4 * i)), 32'(4 * i + 4), 1'b1);
            cyc(1'b1, 1'b0, 1'b0, 32'h0);
            sb_check("stream");
            chk("stream_addr", 64'(bus.imem_addr), 64'(4 * i + 4));
            if (i == 0) begin
                chk("wrap_instr", 64'(bus2.ifid_instr), 64'(word(32'hFFFF_FFFC)));
                chk("wrap_pc4",   64'(bus2.ifid_pc4),   64'd0);
                chk("wrap_addr1", 64'(bus2.imem_addr),  64'd0);
            end
        end

        // Wait states at PC=12
        for (int i = 0; i < 2; i++) begin
            push(32'h0000_0000, 32'h0, 1'b0);
            cyc(1'b0, 1'b0, 1'b0, 32'h0);
            sb_check("wait");
            chk("wait_addr", 64'(bus.imem_addr), 64'd12);
        end
        push(32'h0000_0000, 32'h0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        sb_check("wait_stall");
        push(word(32'd12), 32'd16, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        sb_check("wait_done");
        chk("wait_done_addr", 64'(bus.imem_addr), 64'd16);

        // Stall with capture at PC=16
        push(word(32'd12), 32'd16, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        sb_check("cap");
        chk("cap_addr", 64'(bus.imem_addr), 64'd20);
        chk("cap_req",  64'(bus.imem_req),  64'd0);
        push(word(32'd12), 32'd16, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        sb_check("held");
        chk("held_addr", 64'(bus.imem_addr), 64'd20);
        chk("held_req",  64'(bus.imem_req),  64'd0);
        push(word(32'd16), 32'd20, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        sb_check("release");
        chk("release_req",  64'(bus.imem_req),  64'd1);
        chk("release_addr", 64'(bus.imem_addr), 64'd20);
        push(word(32'd20), 32'd24, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        sb_check("resume");

        // Branch over stall with a captured word at 24
        push(word(32'd20), 32'd24, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        sb_check("cap2");
`ifdef IF_DELAY_SLOT_EN
        push(word(32'd20), 32'd24, 1'b1);
`else
        push(32'h0000_0000, 32'h0, 1'b0);
`endif
        cyc(1'b1, 1'b1, 1'b1, 32'h0000_0040);
        sb_check("br_stall");
        chk("br_stall_addr", 64'(bus.imem_addr), 64'h40);
        chk("br_stall_req",  64'(bus.imem_req),  64'd1);
        push(word(32'h40), 32'h44, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        sb_check("br_target");

        // Branch in FETCH discards same-cycle data
        push(32'h0000_0000, 32'h0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 32'h0000_0100);
        sb_check("br_fetch");
        chk("br_fetch_addr", 64'(bus.imem_addr), 64'h100);
        push(word(32'h100), 32'h104, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        sb_check("br_fetch_next");

        // Asynchronous reset mid-cycle
        #2;
        clr_n = 1'b0;
        #1;
        chk("arst_req",   64'(bus.imem_req),   64'd0);
        chk("arst_addr",  64'(bus.imem_addr),  64'd0);
        chk("arst_instr", 64'(bus.ifid_instr), 64'd0);
        chk("arst_valid", 64'(bus.ifid_valid), 64'd0);
        @(negedge clk);
        clr_n = 1'b1;
        #1;

        // Branch during BOOT
        push(32'h0000_0000, 32'h0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 32'h0000_0080);
        sb_check("boot_br");
        chk("boot_br_addr", 64'(bus.imem_addr), 64'h80);
        chk("boot_br_req",  64'(bus.imem_req),  64'd1);
        push(word(32'h80), 32'h84, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        sb_check("boot_br_next");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
